// File: rtl/spi_pwm_pkg.sv
// Shared command-byte layout, decoder states and sizing helpers for the SPI PWM controller.
package spi_pwm_pkg;
   localparam int CMD_CH_LSB  = 0;
   localparam int CMD_CH_W    = 4;
   localparam int CMD_SEL_BIT = 4;
   localparam int CMD_WR_BIT  = 5;
   localparam int CMD_RSV_LSB = 6;
   localparam int CMD_RSV_MSB = 7;
   localparam int IDX_W       = 2;

   typedef enum logic [1:0] {IDLE, DATA, DISCARD} state_t;

   function automatic int bytes_of(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int ch_bits(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction
endpackage

// File: rtl/spi_pwm_regbank.sv
// Freq/duty register bank with update pulses and byte read mux.
// `define SPI_PWM_SHADOW_EN to stage writes in shadow registers that commit when ss rises.
module spi_pwm_regbank
   import spi_pwm_pkg::*;
#(
   parameter int NUM_CH   = 8,
   parameter int DATA_W   = 16,
   parameter int FREQ_RST = 400,
   parameter int DUTY_RST = 0,
   parameter int CH_W     = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
`ifdef SPI_PWM_SHADOW_EN
   input  logic                     i_ss,
`endif
   input  logic                     i_wr_en,
   input  logic [CH_W-1:0]          i_wr_ch,
   input  logic                     i_wr_sel,
   input  logic [DATA_W-1:0]        i_wr_data,
   input  logic [CH_W-1:0]          i_rd_ch,
   input  logic                     i_rd_sel,
   input  logic [IDX_W-1:0]         i_rd_idx,
   output logic [7:0]               o_rd_byte,
   output logic [NUM_CH*DATA_W-1:0] freq_o,
   output logic [NUM_CH*DATA_W-1:0] duty_o,
   output logic [NUM_CH-1:0]        upd_o
);
   logic [NUM_CH-1:0][DATA_W-1:0] r_freq, r_duty, w_rd_freq, w_rd_duty;
   logic [NUM_CH-1:0]             w_wr_hit;
   logic [DATA_W-1:0]             w_rd_word;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) w_wr_hit[c] = i_wr_en && (i_wr_ch == CH_W'(c));
   end

`ifdef SPI_PWM_SHADOW_EN
   logic [NUM_CH-1:0][DATA_W-1:0] r_sh_freq, r_sh_duty;
   logic [NUM_CH-1:0]             r_dirty;
   logic                          r_ss_q;
   logic                          w_commit;

   // ss rising edge ends the frame and publishes every staged word at once
   assign w_commit = i_ss & ~r_ss_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_freq[c]    <= DATA_W'(FREQ_RST);
            r_duty[c]    <= DATA_W'(DUTY_RST);
            r_sh_freq[c] <= DATA_W'(FREQ_RST);
            r_sh_duty[c] <= DATA_W'(DUTY_RST);
         end
         r_dirty <= '0;
         r_ss_q  <= 1'b1;
         upd_o   <= '0;
      end else begin
         r_ss_q <= i_ss;
         upd_o  <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_wr_hit[c]) begin
               if (i_wr_sel) r_sh_duty[c] <= i_wr_data;
               else          r_sh_freq[c] <= i_wr_data;
            end
         end
         if (w_commit) begin
            r_freq  <= r_sh_freq;
            r_duty  <= r_sh_duty;
            upd_o   <= r_dirty;
            r_dirty <= '0;
         end else begin
            r_dirty <= r_dirty | w_wr_hit;
         end
      end
   end

   assign w_rd_freq = r_sh_freq;
   assign w_rd_duty = r_sh_duty;
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_freq[c] <= DATA_W'(FREQ_RST);
            r_duty[c] <= DATA_W'(DUTY_RST);
         end
         upd_o <= '0;
      end else begin
         upd_o <= w_wr_hit;
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_wr_hit[c]) begin
               if (i_wr_sel) r_duty[c] <= i_wr_data;
               else          r_freq[c] <= i_wr_data;
            end
         end
      end
   end

   assign w_rd_freq = r_freq;
   assign w_rd_duty = r_duty;
`endif

   assign freq_o    = r_freq;
   assign duty_o    = r_duty;
   assign w_rd_word = i_rd_sel ? w_rd_duty[i_rd_ch] : w_rd_freq[i_rd_ch];
   assign o_rd_byte = 8'(w_rd_word >> {i_rd_idx, 3'b000});
endmodule

// File: rtl/spi_pwm_ctrl.sv
// SPI byte-stream decoder for NUM_CH PWM freq/duty registers with auto-incrementing channel.
// `define SPI_PWM_SHADOW_EN for shadowed writes committed at frame end.
module spi_pwm_ctrl
   import spi_pwm_pkg::*;
#(
   parameter int NUM_CH   = 8,
   parameter int DATA_W   = 16,
   parameter int FREQ_RST = 400,
   parameter int DUTY_RST = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ss,
   input  logic                     rx_byte_available,
   input  logic [7:0]               rx_byte,
   output logic [7:0]               tx_byte,
   output logic [NUM_CH*DATA_W-1:0] freq_o,
   output logic [NUM_CH*DATA_W-1:0] duty_o,
   output logic [NUM_CH-1:0]        upd_o,
   output logic                     cmd_err
);
   localparam int BYTES = bytes_of(DATA_W);
   localparam int CH_W  = ch_bits(NUM_CH);

   state_t            r_state, w_state_nxt;
   logic              r_avail_q, w_stb;
   logic [CH_W-1:0]   r_ch, w_ch_inc, w_rd_ch;
   logic              r_sel, r_wr, w_rd_sel;
   logic [IDX_W-1:0]  r_idx, w_rd_idx;
   logic [DATA_W-1:0] r_buf, w_wdata;
   logic [7:0]        w_rd_byte;
   logic              w_last, w_cmd_bad, w_cmd_acc, w_wr_en, w_tx_ld, w_data_stb;

   assign w_stb      = rx_byte_available & ~r_avail_q;
   assign w_last     = (r_idx == IDX_W'(BYTES - 1));
   assign w_ch_inc   = (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + CH_W'(1);
   assign w_data_stb = w_stb && !ss && (r_state == DATA);
   assign w_cmd_bad  = ({28'd0, rx_byte[CMD_CH_LSB +: CMD_CH_W]} >= 32'(NUM_CH))
                     || (|rx_byte[CMD_RSV_MSB:CMD_RSV_LSB]);

   always_comb begin
      w_state_nxt = r_state;
      w_cmd_acc   = 1'b0;
      w_wr_en     = 1'b0;
      w_tx_ld     = 1'b0;
      w_rd_ch     = r_ch;
      w_rd_sel    = r_sel;
      w_rd_idx    = r_idx + IDX_W'(1);
      w_wdata     = r_buf;
      w_wdata[(BYTES-1)*8 +: 8] = rx_byte;
      if (ss) begin
         w_state_nxt = IDLE;
      end else if (w_stb) begin
         case (r_state)
            IDLE: begin
               if (w_cmd_bad) begin
                  w_state_nxt = DISCARD;
               end else begin
                  w_cmd_acc   = 1'b1;
                  w_tx_ld     = 1'b1;
                  w_rd_ch     = rx_byte[CMD_CH_LSB +: CH_W];
                  w_rd_sel    = rx_byte[CMD_SEL_BIT];
                  w_rd_idx    = '0;
                  w_state_nxt = DATA;
               end
            end
            DATA: begin
               // prefetch the byte the master clocks out next, crossing into ch+1 after a word
               w_tx_ld = 1'b1;
               if (w_last) begin
                  w_rd_ch  = w_ch_inc;
                  w_rd_idx = '0;
                  w_wr_en  = r_wr;
               end
            end
            DISCARD: ;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_avail_q <= 1'b0;
         r_ch      <= '0;
         r_sel     <= 1'b0;
         r_wr      <= 1'b0;
         r_idx     <= '0;
         r_buf     <= '0;
         tx_byte   <= '0;
         cmd_err   <= 1'b0;
      end else begin
         r_avail_q <= rx_byte_available;
         r_state   <= w_state_nxt;
         cmd_err   <= w_stb && !ss && (r_state == IDLE) && w_cmd_bad;
         if (w_tx_ld) tx_byte <= w_rd_byte;
         if (ss) begin
            r_idx <= '0;
         end else if (w_cmd_acc) begin
            r_ch  <= rx_byte[CMD_CH_LSB +: CH_W];
            r_sel <= rx_byte[CMD_SEL_BIT];
            r_wr  <= rx_byte[CMD_WR_BIT];
            r_idx <= '0;
         end else if (w_data_stb) begin
            for (int b = 0; b < BYTES; b++)
               if (r_idx == IDX_W'(b)) r_buf[b*8 +: 8] <= rx_byte;
            if (w_last) begin
               r_idx <= '0;
               r_ch  <= w_ch_inc;
            end else begin
               r_idx <= r_idx + IDX_W'(1);
            end
         end
      end
   end

   spi_pwm_regbank #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FREQ_RST(FREQ_RST), .DUTY_RST(DUTY_RST), .CH_W(CH_W)
   ) u_regbank (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef SPI_PWM_SHADOW_EN
      .i_ss      (ss),
`endif
      .i_wr_en   (w_wr_en),
      .i_wr_ch   (r_ch),
      .i_wr_sel  (r_sel),
      .i_wr_data (w_wdata),
      .i_rd_ch   (w_rd_ch),
      .i_rd_sel  (w_rd_sel),
      .i_rd_idx  (w_rd_idx),
      .o_rd_byte (w_rd_byte),
      .freq_o    (freq_o),
      .duty_o    (duty_o),
      .upd_o     (upd_o)
   );
endmodule

// File: tb/tb_spi_pwm_ctrl.sv
// Directed bench for spi_pwm_ctrl (NUM_CH=8, DATA_W=16); also covers the SPI_PWM_SHADOW_EN build.
module tb_spi_pwm_ctrl;
   localparam int NUM_CH = 8;
   localparam int DATA_W = 16;

   logic                     clk = 1'b0;
   logic                     rst_n, ss, rx_byte_available;
   logic [7:0]               rx_byte, tx_byte;
   logic [NUM_CH*DATA_W-1:0] freq_o, duty_o;
   logic [NUM_CH-1:0]        upd_o;
   logic                     cmd_err;

   int         n_chk  = 0;
   int         n_fail = 0;
   logic [7:0] s_tx, s_upd;
   logic       s_err;

`ifdef SPI_PWM_SHADOW_EN
   localparam bit SH = 1'b1;
`else
   localparam bit SH = 1'b0;
`endif

   always #5 clk = ~clk;

   spi_pwm_ctrl #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FREQ_RST(400), .DUTY_RST(0)) dut (
      .clk(clk), .rst_n(rst_n), .ss(ss), .rx_byte_available(rx_byte_available),
      .rx_byte(rx_byte), .tx_byte(tx_byte), .freq_o(freq_o), .duty_o(duty_o),
      .upd_o(upd_o), .cmd_err(cmd_err)
   );

   function automatic logic [DATA_W-1:0] fr(input int c);
      return freq_o[c*DATA_W +: DATA_W];
   endfunction

   function automatic logic [DATA_W-1:0] du(input int c);
      return duty_o[c*DATA_W +: DATA_W];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one strobe; outputs are captured right after the decoding edge
   task automatic send(input logic [7:0] b);
      rx_byte           = b;
      rx_byte_available = 1'b1;
      tick();
      s_tx  = tx_byte;
      s_upd = upd_o;
      s_err = cmd_err;
      rx_byte_available = 1'b0;
      tick();
   endtask

   task automatic begin_frame();
      ss = 1'b0;
      tick();
   endtask

   task automatic end_frame();
      ss = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; ss = 1'b1; rx_byte_available = 1'b0; rx_byte = 8'h00;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      for (int c = 0; c < NUM_CH; c++) begin
         check("rst_freq", 32'(fr(c)), 32'd400);
         check("rst_duty", 32'(du(c)), 32'd0);
      end
      check("rst_tx", 32'(tx_byte), 32'h00);
      check("rst_upd", 32'(upd_o), 32'h00);
      check("rst_err", 32'(cmd_err), 32'h0);

      // duty ch2 = 1000, duty ch3 = 16 via auto-increment
      begin_frame();
      send(8'h32); check("wr_cmd_err", 32'(s_err), 32'h0);
      send(8'hE8); check("wr_b0_upd", 32'(s_upd), 32'h00);
      send(8'h03); check("wr_ch2_upd", 32'(s_upd), SH ? 32'h00 : 32'h04);
      check("wr_ch2_live", 32'(du(2)), SH ? 32'd0 : 32'd1000);
      send(8'h10);
      send(8'h00); check("wr_ch3_upd", 32'(s_upd), SH ? 32'h00 : 32'h08);
      end_frame();
      check("wr_end_upd", 32'(upd_o), SH ? 32'h0C : 32'h00);
      check("wr_duty2", 32'(du(2)), 32'd1000);
      check("wr_duty3", 32'(du(3)), 32'd16);
      check("wr_freq2", 32'(fr(2)), 32'd400);

      // read freq ch7 and wrap into ch0, ch1
      begin_frame();
      send(8'h07); check("rd_ch7_b0", 32'(s_tx), 32'h90);
      send(8'hAA); check("rd_ch7_b1", 32'(s_tx), 32'h01);
      send(8'hAA); check("rd_ch0_b0", 32'(s_tx), 32'h90);
      send(8'hAA); check("rd_ch0_b1", 32'(s_tx), 32'h01);
      check("rd_no_upd", 32'(s_upd), 32'h00);
      send(8'hAA); check("rd_ch1_b0", 32'(s_tx), 32'h90);
      end_frame();

      begin_frame();
      send(8'h12); check("rd_duty2_b0", 32'(s_tx), 32'hE8);
      send(8'h00); check("rd_duty2_b1", 32'(s_tx), 32'h03);
      end_frame();

      // rejected commands; trailing bytes must not act as a command
      begin_frame();
      send(8'h0A); check("bad_ch_err", 32'(s_err), 32'h1);
      check("bad_ch_tx_hold", 32'(s_tx), 32'h03);
      send(8'h35); check("discard_err", 32'(s_err), 32'h0);
      check("discard_tx", 32'(s_tx), 32'h03);
      send(8'h00);
      send(8'h00); check("discard_upd", 32'(s_upd), 32'h00);
      end_frame();
      check("discard_end_upd", 32'(upd_o), 32'h00);
      begin_frame();
      send(8'h40); check("bad_rsv_err", 32'(s_err), 32'h1);
      end_frame();
      check("bad_duty5", 32'(du(5)), 32'd0);
      check("bad_duty2", 32'(du(2)), 32'd1000);

      // partial word dropped at frame end
      begin_frame();
      send(8'h21);
      send(8'h55);
      end_frame();
      check("part_freq1", 32'(fr(1)), 32'd400);
      check("part_upd", 32'(upd_o), 32'h00);
      begin_frame();
      send(8'h21);
      send(8'h34);
      send(8'h12); check("full_upd", 32'(s_upd), SH ? 32'h00 : 32'h02);
      end_frame();
      check("full_end_upd", 32'(upd_o), SH ? 32'h02 : 32'h00);
      check("full_freq1", 32'(fr(1)), 32'h1234);

      // strobe while ss is high is ignored
      send(8'h0A);
      check("ss_win_err", 32'(s_err), 32'h0);
      check("ss_win_tx", 32'(s_tx), 32'h90);

      // reset mid-frame, then a clean write of freq ch0
      begin_frame();
      send(8'h20);
      send(8'h11);
      rst_n = 1'b0;
      #2;
      check("mid_rst_freq1", 32'(fr(1)), 32'd400);
      check("mid_rst_tx", 32'(tx_byte), 32'h00);
      ss = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      begin_frame();
      send(8'h20);
      send(8'h34);
      send(8'h12); check("ch0_upd", 32'(s_upd), SH ? 32'h00 : 32'h01);
      check("ch0_pre_ss", 32'(fr(0)), SH ? 32'd400 : 32'h1234);
      end_frame();
      check("ch0_end_upd", 32'(upd_o), SH ? 32'h01 : 32'h00);
      tick();
      check("ch0_upd_once", 32'(upd_o), 32'h00);
      check("ch0_freq", 32'(fr(0)), 32'h1234);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_pwm_ctrl.md
# spi_pwm_ctrl

Multi-channel PWM register controller that sits between `spi_slave` and a bank of `pwm` instances. Decodes the SPI byte stream into frequency and duty-cycle register reads and writes for `NUM_CH` channels, with auto-incrementing channel address and atomic per-word commits. Parametrised successor to the single-channel decoder in `main`. Adds asynchronous reset, range checking, error reporting and optional shadowed frame-commit.

## Interface
- `NUM_CH`, 8: number of PWM channels, 1..16.
- `DATA_W`, 16: register width; multiple of 8, range 8..32; `BYTES = DATA_W/8`.
- `FREQ_RST`, 400: reset value of every frequency register.
- `DUTY_RST`, 0: reset value of every duty register.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ss`  in  1  SPI slave select, active-low; high means frame end or idle.
- `rx_byte_available`  in  1  level from `spi_slave`; a rising edge marks a new `rx_byte`.
- `rx_byte`  in  8  received byte.
- `tx_byte`  out  8  next byte for `spi_slave` to shift out.
- `freq_o`  out  NUM_CH*DATA_W  live frequency registers; channel c occupies `[c*DATA_W +: DATA_W]`.
- `duty_o`  out  NUM_CH*DATA_W  live duty registers, packed the same way as `freq_o`.
- `upd_o`  out  NUM_CH  one-cycle pulse per channel when its live freq or duty value is written.
- `cmd_err`  out  1  one-cycle pulse when a command byte is rejected.

## Operation
- **Strobe:** `stb = rx_byte_available & ~avail_q`, where `avail_q` is a register that resets to 0. All decode happens only on `stb`.
- **States:**
  - IDLE: wait for the command byte.
  - DATA: transfer payload bytes.
  - DISCARD: ignore bytes until the frame ends.
- **`ss` high:** forces IDLE on the same clock edge, regardless of `stb`. Any partially received write word is dropped and `byte_idx` clears.
- **Command byte:** `[3:0]` start channel, `[4]` sel (1 = duty, 0 = freq), `[5]` write, `[7:6]` reserved.
  - Channel ≥ NUM_CH, or `[7:6]` ≠ 0: pulse `cmd_err`, go to DISCARD, leave all registers untouched.
  - Otherwise: latch `ch`, `sel`, `wr`, clear `byte_idx`, go to DATA.
- **Byte order:** little-endian. Byte k carries bits `[8k +: 8]`.
- **Write, DATA state:**
  - Bytes 0..BYTES-2 go into `buf`.
  - On byte BYTES-1, the word `{rx_byte, buf}` is committed to register (`ch`, `sel`) in one edge, so a half-written word is never visible.
  - Then `ch` advances and `byte_idx` returns to 0.
- **Read:**
  - On the accepted command byte, `tx_byte` loads byte 0 of (`ch`, `sel`).
  - On each DATA byte, `tx_byte` loads the next byte. After byte BYTES-1 it loads byte 0 of channel `ch+1`.
  - Received data is ignored.
- **Channel wrap:** `ch` wraps from NUM_CH-1 to 0, so a stream continues cyclically through the channels.
- **Rejected command:** `tx_byte` holds its last value.

## Timing
- Reset values: `tx_byte` = 0; every `freq_o` slot = FREQ_RST; every `duty_o` slot = DUTY_RST; `upd_o` = 0; `cmd_err` = 0; state = IDLE; `ch`, `byte_idx`, `buf` = 0.
- All register updates, `tx_byte` loads and pulses occur on the `clk` edge that samples `stb` = 1. They are visible one cycle after `rx_byte_available` is first seen high.
- `upd_o[c]` is high for exactly the cycle after the live register of channel c changes.
- If `stb` and `ss` = 1 occur in the same cycle, `ss` wins and the byte is discarded.
- Reset asserted mid-frame restores all reset values immediately. Decoding resumes at the first command byte after `rst_n` rises.
- A new strobe needs `rx_byte_available` low for at least one `clk` cycle.

## Configuration
- `SPI_PWM_SHADOW_EN`
  - Defined: writes commit into shadow registers, not the live ones.
  - On the first `clk` edge where `ss` = 1 after having been 0, all shadow values copy to `freq_o`/`duty_o` in one cycle. `upd_o` pulses for every channel written during the frame.
  - Reads return the shadow value.
  - Shadow registers reset to FREQ_RST/DUTY_RST.
- Undefined: words commit straight to the live registers, as described in Operation; no shadow storage is built.

## Structure
- Package `spi_pwm_pkg`:
  - command bit positions (`CMD_CH_LSB`, `CMD_SEL_BIT`, `CMD_WR_BIT`, `CMD_RSV_MSB`);
  - the state enum (IDLE, DATA, DISCARD);
  - a `BYTES` helper function.
- Sub-module `spi_pwm_regbank`: the freq/duty arrays, optional shadow copy and commit, `upd_o` generation, and a read-byte mux by (`ch`, `sel`, `byte_idx`).
- The top level holds the strobe detector, the FSM and the `tx_byte` register.

## Test plan
- Reset with NUM_CH=8, DATA_W=16 → every `freq_o` slot = 400, every `duty_o` slot = 0, `tx_byte` = 0.
- Write frame 0x32, 0xE8, 0x03, 0x10, 0x00 → duty ch2 = 1000, duty ch3 = 16; `upd_o[2]` then `upd_o[3]` pulse.
- Read frame 0x07 followed by four dummy bytes → `tx_byte` sequence 0x90, 0x01 (400 from ch7), then 0x90, 0x01 (400 from ch0, after wrap).
- Command 0x0A, then command 0x40 → `cmd_err` pulses for each; no register changes; following bytes are ignored until `ss` goes high.
- Write frame 0x21, 0x55, then `ss` high → freq ch1 stays 400 and no `upd_o` pulse; the next frame decodes 0x21 as a command.
- With `SPI_PWM_SHADOW_EN`: write freq ch0 = 0x1234 → `freq_o` ch0 stays 400 until `ss` rises, then = 0x1234 with `upd_o[0]` pulsing once.
